bus_cycle_ctrl: RTL and testbench

//   Upstream bus master for the CPLD peripherals (bar LED latch, SRAM window).

---
 rtl/bus_cycle_ctrl_pkg.sv | 20 ++
 rtl/bus_cycle_ctrl_if.sv | 26 ++
 rtl/bus_cycle_ctrl_addr_decode.sv | 16 +
 rtl/bus_cycle_ctrl.sv | 126 ++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared definitions for the peripheral bus cycle controller: FSM states,
// default address map and the value returned for reads of unmapped addresses.
package bus_cycle_ctrl_pkg;

  localparam int unsigned DataW = 8;

  localparam logic [7:0] LedAddrDefault = 8'h00;
  localparam logic [7:0] MemBaseDefault = 8'h80;

  localparam logic [DataW:1] UnmappedRdata = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StDone
  } state_e;

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Host-side four-phase req/ack transaction interface of the bus cycle controller.
interface bus_cycle_ctrl_if
  import bus_cycle_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic              req;
  logic              host_rw;
  logic [ADDR_W-1:0] host_addr;
  logic [DataW:1]    host_wdata;
  logic [DataW:1]    host_rdata;
  logic              ack;
  logic              busy;

  modport master (
    output req, host_rw, host_addr, host_wdata,
    input  host_rdata, ack, busy
  );

  modport slave (
    input  req, host_rw, host_addr, host_wdata,
    output host_rdata, ack, busy
  );

endinterface

// File: rtl/bus_cycle_ctrl_addr_decode.sv
// Combinational address decode: selects the bar LED latch or the SRAM window.
module bus_cycle_ctrl_addr_decode #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] LED_ADDR = '0,
  parameter logic [ADDR_W-1:0] MEM_BASE = '1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              sel_led,
  output logic              sel_mem
);

  assign sel_led = (addr == LED_ADDR);
  // LED wins on overlap so the two selects can never both be active.
  assign sel_mem = (addr >= MEM_BASE) && !sel_led;

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Bus master for the CPLD peripherals: turns a req/ack host transaction into a
// SETUP / STROBE / HOLD cycle with ce_l, rw and write data sequenced safely.
module bus_cycle_ctrl
  import bus_cycle_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       STROBE_CYC = 2,
  parameter logic [ADDR_W-1:0] LED_ADDR   = ADDR_W'(LedAddrDefault),
  parameter logic [ADDR_W-1:0] MEM_BASE   = ADDR_W'(MemBaseDefault)
) (
  input  logic           clk,
  input  logic           reset,
  bus_cycle_ctrl_if.slave host,
  output logic           ce_led_l,
  output logic           ce_mem_l,
  output logic           rw,
  inout  wire [DataW:1]  data
);

  localparam int unsigned     CntW    = $clog2(STROBE_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STROBE_CYC - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DataW:1]    wdata_q;
  logic [DataW:1]    rdata_q;

  logic sel_led;
  logic sel_mem;
  logic accept;
  logic strobe_last;
  logic drive_en;

  // Decode works on the latched address so host changes mid-cycle are ignored.
  bus_cycle_ctrl_addr_decode #(
    .ADDR_W   (ADDR_W),
    .LED_ADDR (LED_ADDR),
    .MEM_BASE (MEM_BASE)
  ) u_addr_decode (
    .addr    (addr_q),
    .sel_led (sel_led),
    .sel_mem (sel_mem)
  );

  assign accept      = (state_q == StIdle) && host.req;
  assign strobe_last = (cnt_q == CntLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (host.req) state_d = StSetup;
      StSetup:  state_d = StStrobe;
      StStrobe: if (strobe_last) state_d = StHold;
      StHold:   state_d = StDone;
      StDone:   if (!host.req) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ce_led_l  = 1'b1;
    ce_mem_l  = 1'b1;
    rw        = 1'b1;
    drive_en  = 1'b0;
    host.ack  = 1'b0;
    host.busy = 1'b1;
    unique case (state_q)
      StIdle: host.busy = 1'b0;
      StSetup, StHold: begin
        rw       = rw_q;
        drive_en = !rw_q;
      end
      StStrobe: begin
        rw       = rw_q;
        drive_en = !rw_q;
        ce_led_l = !sel_led;
        ce_mem_l = !sel_mem;
      end
      StDone: host.ack = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == StStrobe && !strobe_last) begin
      cnt_q <= cnt_q + CntW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        rw_q    <= host.host_rw;
        addr_q  <= host.host_addr;
        wdata_q <= host.host_wdata;
      end
      // Read data is captured on the edge that ends the strobe.
      if (state_q == StStrobe && strobe_last && rw_q) begin
        rdata_q <= (sel_led || sel_mem) ? data : UnmappedRdata;
      end
    end
  end

  assign host.host_rdata = rdata_q;
  assign data            = drive_en ? wdata_q : 'z;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Randomised scoreboard bench for bus_cycle_ctrl with LED latch / SRAM
// peripheral models and continuous bus-protocol invariant checks.
module tb_bus_cycle_ctrl;
  import bus_cycle_ctrl_pkg::*;

  localparam int unsigned StrobeCyc = 2;
  localparam int          Latency   = StrobeCyc + 3;

  logic clk = 1'b0;
  logic rst;
  logic ce_led_l;
  logic ce_mem_l;
  logic rw;
  wire [8:1] data;

  bus_cycle_ctrl_if #(.ADDR_W(8)) host_bus ();

  bus_cycle_ctrl #(
    .ADDR_W     (8),
    .STROBE_CYC (StrobeCyc),
    .LED_ADDR   (8'h00),
    .MEM_BASE   (8'h80)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .host     (host_bus),
    .ce_led_l (ce_led_l),
    .ce_mem_l (ce_mem_l),
    .rw       (rw),
    .data     (data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Peripheral models; the SRAM has no address pins so it uses the address
  // of the transaction currently being issued.
  logic [7:0] cur_addr = 8'h00;
  bit [8:1]   bar_leds;
  bit [8:1]   sram [256];
  bit         sram_wr [256];
  logic [8:1] periph_drv;

  function automatic logic [8:1] mem_init(input logic [7:0] a);
    return (a == 8'h90) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  function automatic logic [8:1] sram_rd(input logic [7:0] a);
    return sram_wr[a] ? sram[a] : mem_init(a);
  endfunction

  assign periph_drv = !ce_mem_l ? (sram_wr[cur_addr] ? sram[cur_addr] : mem_init(cur_addr)) :
                      !ce_led_l ? bar_leds : 8'h00;
  assign data = rw ? periph_drv : 8'hzz;

  initial forever begin
    @(posedge clk);
    if (!rst && !rw) begin
      if (!ce_mem_l) begin
        sram[cur_addr]    = data;
        sram_wr[cur_addr] = 1'b1;
      end
      if (!ce_led_l) bar_leds = data;
    end
  end

  // Reference state of the peripherals as seen from the host.
  logic [8:1] ref_mem [256];
  logic [8:1] ref_led;

  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [8:1] wdata;
    logic [8:1] exp_rdata;
    int         start;
    int         exp_led;
    int         exp_mem;
  } exp_t;

  exp_t exp_q[$];

  initial begin : monitor
    int   led_lo;
    int   mem_lo;
    logic ack_prev;
    exp_t e;
    led_lo   = 0;
    mem_lo   = 0;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        led_lo   = 0;
        mem_lo   = 0;
        ack_prev = 1'b0;
      end else begin
        if (!ce_led_l) led_lo++;
        if (!ce_mem_l) mem_lo++;
        if (host_bus.ack && !ack_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'(host_bus.ack), 0);
          end else begin
            e = exp_q.pop_front();
            check("latency", 32'(cyc - e.start), 32'(Latency));
            check("led_strobe_cycles", 32'(led_lo), 32'(e.exp_led));
            check("mem_strobe_cycles", 32'(mem_lo), 32'(e.exp_mem));
            check("data_released", 32'(data), 32'h00);
            check("busy_at_ack", 32'(host_bus.busy), 1);
            if (e.rd) begin
              check("host_rdata", 32'(host_bus.host_rdata), 32'(e.exp_rdata));
            end else if (e.addr == 8'h00) begin
              check("bar_leds", 32'(bar_leds), 32'(e.wdata));
            end else if (e.addr >= 8'h80) begin
              check("sram_write", 32'(sram_rd(e.addr)), 32'(e.wdata));
            end
          end
          led_lo = 0;
          mem_lo = 0;
        end
        ack_prev = host_bus.ack;
      end
    end
  end

  // Bus invariants: one strobe at a time, rw/data frozen around any strobe.
  initial begin : invariants
    logic       p_rst;
    logic       p_rw;
    logic       p_led;
    logic       p_mem;
    logic [8:1] p_data;
    p_rst  = 1'b1;
    p_rw   = 1'b1;
    p_led  = 1'b1;
    p_mem  = 1'b1;
    p_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && !p_rst) begin
        check("one_ce_low", 32'(ce_led_l | ce_mem_l), 1);
        if (!(p_led && p_mem) || !(ce_led_l && ce_mem_l)) begin
          check("rw_stable", 32'(rw), 32'(p_rw));
          if (!rw) check("data_stable", 32'(data), 32'(p_data));
        end
      end
      p_rst  = rst;
      p_rw   = rw;
      p_led  = ce_led_l;
      p_mem  = ce_mem_l;
      p_data = data;
    end
  end

  // Called at a negedge; returns at a negedge with the DUT back in idle.
  task automatic do_txn(input bit rd, input logic [7:0] addr, input logic [8:1] wdata,
                        input int hold, input bit early_drop, input bit scramble);
    exp_t e;
    bit   got;
    e.rd        = rd;
    e.addr      = addr;
    e.wdata     = wdata;
    e.start     = cyc;
    e.exp_led   = (addr == 8'h00) ? int'(StrobeCyc) : 0;
    e.exp_mem   = (addr >= 8'h80) ? int'(StrobeCyc) : 0;
    e.exp_rdata = (addr == 8'h00) ? ref_led : (addr >= 8'h80) ? ref_mem[addr] : 8'hFF;
    if (!rd) begin
      if (addr == 8'h00) ref_led = wdata;
      else if (addr >= 8'h80) ref_mem[addr] = wdata;
    end
    exp_q.push_back(e);
    cur_addr            = addr;
    host_bus.req        = 1'b1;
    host_bus.host_rw    = rd;
    host_bus.host_addr  = addr;
    host_bus.host_wdata = wdata;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (early_drop) host_bus.req = 1'b0;
        if (scramble) begin
          host_bus.host_addr  = 8'($urandom);
          host_bus.host_rw    = 1'($urandom);
          host_bus.host_wdata = 8'($urandom);
        end
      end
      if (host_bus.ack) got = 1'b1;
    end
    if (!got) begin
      check("ack_timeout", 32'(got), 1);
      host_bus.req = 1'b0;
      @(negedge clk);
    end else if (early_drop) begin
      @(negedge clk);
      check("ack_one_cycle", 32'(host_bus.ack), 0);
      check("busy_idle", 32'(host_bus.busy), 0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("ack_held", 32'(host_bus.ack), 1);
        check("no_second_strobe", 32'({ce_led_l, ce_mem_l}), 32'h3);
      end
      host_bus.req = 1'b0;
      @(negedge clk);
      check("ack_drop", 32'(host_bus.ack), 0);
      check("busy_drop", 32'(host_bus.busy), 0);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] a;
    rst                 = 1'b1;
    host_bus.req        = 1'b0;
    host_bus.host_rw    = 1'b0;
    host_bus.host_addr  = 8'h00;
    host_bus.host_wdata = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(8'(i));
    ref_led = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_ce_led_l", 32'(ce_led_l), 1);
    check("rst_ce_mem_l", 32'(ce_mem_l), 1);
    check("rst_rw", 32'(rw), 1);
    check("rst_ack", 32'(host_bus.ack), 0);
    check("rst_busy", 32'(host_bus.busy), 0);
    check("rst_rdata", 32'(host_bus.host_rdata), 32'h00);
    check("rst_data_released", 32'(data), 32'h00);
    #2 rst = 1'b0;
    @(negedge clk);

    // Abort a write to SRAM in the middle of its strobe.
    cur_addr            = 8'h85;
    host_bus.req        = 1'b1;
    host_bus.host_rw    = 1'b0;
    host_bus.host_addr  = 8'h85;
    host_bus.host_wdata = 8'h33;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_strobe", 32'(ce_mem_l), 0);
    #2 rst = 1'b1;
    #1;
    check("abort_ce_mem_l", 32'(ce_mem_l), 1);
    check("abort_ce_led_l", 32'(ce_led_l), 1);
    check("abort_ack", 32'(host_bus.ack), 0);
    check("abort_busy", 32'(host_bus.busy), 0);
    check("abort_rw", 32'(rw), 1);
    check("abort_data_released", 32'(data), 32'h00);
    host_bus.req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("abort_no_sram_write", 32'(sram_rd(8'h85)), 32'(mem_init(8'h85)));

    do_txn(1'b0, 8'h00, 8'h4F, 0, 1'b0, 1'b0);
    do_txn(1'b1, 8'h90, 8'h00, 0, 1'b0, 1'b0);
    do_txn(1'b1, 8'h40, 8'h00, 0, 1'b0, 1'b0);
    do_txn(1'b0, 8'h81, 8'h3C, 10, 1'b0, 1'b1);
    do_txn(1'b1, 8'h81, 8'h00, 0, 1'b1, 1'b0);
    do_txn(1'b1, 8'h00, 8'h00, 1, 1'b0, 1'b1);
    do_txn(1'b0, 8'h7F, 8'hC3, 0, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 8'h00;
        1:       a = 8'($urandom_range(128, 135));
        2:       a = 8'($urandom_range(128, 255));
        default: a = 8'($urandom_range(1, 127));
      endcase
      do_txn(1'($urandom), a, 8'($urandom), int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
